// File: rtl/game_screen_ctrl.sv
// Screen sequencer for the runner game: title -> play -> dying -> game-over.
// Drives the game run/reset strobes and selects the final pixel colour on vsync-timed frames.
module game_screen_ctrl #(
    parameter int unsigned DYING_FRAMES = 60,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter int unsigned FADE_FRAMES  = 4,
    parameter int unsigned PIPE_DELAY   = 2,
    parameter logic [11:0] TITLE_COLOR  = 12'h00F,
    parameter logic [11:0] FLASH_COLOR  = 12'hF00
) (
    input  logic        system_clock_in,
    input  logic        reset_in,
    input  logic        vsync,
    input  logic        blank,
    input  logic        start_btn,
    input  logic        player_dead,
    input  logic [11:0] game_rgb,
    input  logic [11:0] gameover_rgb,
    output logic [11:0] rgb_out,
    output logic [1:0]  state_out,
    output logic        game_run,
    output logic        game_reset
);

    localparam int unsigned MAX_FRAMES = (DYING_FRAMES > FADE_FRAMES) ? DYING_FRAMES : FADE_FRAMES;
    localparam int unsigned FCW        = $clog2(MAX_FRAMES) + 1;
    localparam int unsigned LVLW       = 4;
    localparam int unsigned RGBW       = 12;

    typedef enum logic [1:0] {
        ST_TITLE    = 2'd0,
        ST_PLAY     = 2'd1,
        ST_DYING    = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
    logic [LVLW-1:0]   fade_lvl_q, fade_lvl_d;
    logic              flash_q, flash_d;
    logic              vsync_q, start_q;
    logic [RGBW-1:0]   rgb_q, rgb_d;
    logic              game_run_q, game_run_d;
    logic              game_reset_q, game_reset_d;
    logic [RGBW-1:0]   fade_rgb;
    logic              blank_d;
    logic              frame_tick;
    logic              start_rise;
    logic [31:0]       cnt_inc;

    assign frame_tick = vsync_q & ~vsync;
    assign start_rise = ~start_q & start_btn;
    assign cnt_inc    = 32'(frame_cnt_q) + 32'd1;

    assign rgb_out    = rgb_q;
    assign state_out  = state_q;
    assign game_run   = game_run_q;
    assign game_reset = game_reset_q;

    // Align blank with the renderer pixel latency
    if (PIPE_DELAY == 0) begin : g_no_pipe
        assign blank_d = blank;
    end else begin : g_pipe
        logic [PIPE_DELAY-1:0] blank_pipe_q, blank_pipe_d;
        assign blank_pipe_d = (blank_pipe_q << 1) | PIPE_DELAY'(blank);
        assign blank_d      = blank_pipe_q[PIPE_DELAY-1];
        always_ff @(posedge system_clock_in) begin
            if (reset_in) blank_pipe_q <= '0;
            else          blank_pipe_q <= blank_pipe_d;
        end
    end

    // State register
    always_ff @(posedge system_clock_in) begin
        if (reset_in) state_q <= ST_TITLE;
        else          state_q <= state_d;
    end

    // Next-state and frame counters
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        fade_lvl_d  = fade_lvl_q;
        flash_d     = flash_q;
        case (state_q)
            ST_TITLE: begin
                if (start_rise) begin
                    state_d     = ST_PLAY;
                    frame_cnt_d = '0;
                end
            end
            ST_PLAY: begin
                if (player_dead) begin
                    state_d     = ST_DYING;
                    frame_cnt_d = '0;
                    flash_d     = 1'b0;
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    frame_cnt_d = FCW'(cnt_inc);
                    if ((cnt_inc % FLASH_FRAMES) == 32'd0) flash_d = ~flash_q;
                    if (cnt_inc == DYING_FRAMES) begin
                        state_d     = ST_GAMEOVER;
                        frame_cnt_d = '0;
                        fade_lvl_d  = '0;
                    end
                end
            end
            ST_GAMEOVER: begin
                if (frame_tick) begin
                    if (cnt_inc == FADE_FRAMES) begin
                        frame_cnt_d = '0;
                        if (fade_lvl_q != 4'd15) fade_lvl_d = fade_lvl_q + 4'd1;
                    end else begin
                        frame_cnt_d = FCW'(cnt_inc);
                    end
                end
                // Presses before the image is fully faded in are dropped
                if (start_rise && (fade_lvl_q == 4'd15)) begin
                    state_d     = ST_PLAY;
                    frame_cnt_d = '0;
                end
            end
        endcase
    end

    // Per-channel fade: (c * (lvl+1)) >> 4, level 15 is a passthrough
    always_comb begin
        logic [7:0] prod;
        fade_rgb = '0;
        prod     = '0;
        for (int ch = 0; ch < 3; ch++) begin
            prod = 8'(gameover_rgb[ch*4 +: 4]) * (8'(fade_lvl_q) + 8'd1);
            fade_rgb[ch*4 +: 4] = prod[7:4];
        end
    end

    // Outputs
    always_comb begin
        game_run_d   = (state_d == ST_PLAY);
        game_reset_d = (state_d == ST_PLAY) && (state_q != ST_PLAY);
        rgb_d        = '0;
        if (!blank_d) begin
            case (state_q)
                ST_TITLE:    rgb_d = TITLE_COLOR;
                ST_PLAY:     rgb_d = game_rgb;
                ST_DYING:    rgb_d = flash_q ? FLASH_COLOR : game_rgb;
                ST_GAMEOVER: rgb_d = fade_rgb;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge system_clock_in) begin
        if (reset_in) begin
            frame_cnt_q  <= '0;
            fade_lvl_q   <= '0;
            flash_q      <= 1'b0;
            vsync_q      <= 1'b1;
            start_q      <= 1'b1;
            rgb_q        <= '0;
            game_run_q   <= 1'b0;
            game_reset_q <= 1'b1;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            fade_lvl_q   <= fade_lvl_d;
            flash_q      <= flash_d;
            vsync_q      <= vsync;
            start_q      <= start_btn;
            rgb_q        <= rgb_d;
            game_run_q   <= game_run_d;
            game_reset_q <= game_reset_d;
        end
    end

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Directed bench for game_screen_ctrl: a vector table for the main flow plus
// hand-written sequences for fade-in, blanking and mid-game reset.
module tb_game_screen_ctrl;

    logic        clk = 1'b0;
    logic        reset_in, vsync, blank, start_btn, player_dead;
    logic [11:0] game_rgb, gameover_rgb;
    logic [11:0] rgb_out;
    logic [1:0]  state_out;
    logic        game_run, game_reset;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    game_screen_ctrl #(
        .DYING_FRAMES(4),
        .FLASH_FRAMES(2),
        .FADE_FRAMES (1),
        .PIPE_DELAY  (2)
    ) dut (
        .system_clock_in(clk),
        .reset_in       (reset_in),
        .vsync          (vsync),
        .blank          (blank),
        .start_btn      (start_btn),
        .player_dead    (player_dead),
        .game_rgb       (game_rgb),
        .gameover_rgb   (gameover_rgb),
        .rgb_out        (rgb_out),
        .state_out      (state_out),
        .game_run       (game_run),
        .game_reset     (game_reset)
    );

    typedef struct packed {
        logic        rst;
        logic        start;
        logic        dead;
        logic        vs;
        logic [1:0]  st;
        logic [11:0] rgb;
        logic        run;
        logic        grst;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic rst, input logic start, input logic dead,
                                input logic vs, input logic [1:0] st, input logic [11:0] rgb,
                                input logic run, input logic grst);
        vec_t v;
        v.rst = rst; v.start = start; v.dead = dead; v.vs = vs;
        v.st = st; v.rgb = rgb; v.run = run; v.grst = grst;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [11:0] rgb,
                           input logic run, input logic grst);
        chk({tag, ".state"}, 12'(state_out), 12'(st));
        chk({tag, ".rgb"}, rgb_out, rgb);
        chk({tag, ".run"}, 12'(game_run), 12'(run));
        chk({tag, ".grst"}, 12'(game_reset), 12'(grst));
    endtask

    task automatic frame();
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        step();
    endtask

    initial begin
        // rst start dead vsync | state rgb run game_reset
        tbl[0]  = mk(1, 1, 0, 1, 2'd0, 12'h000, 0, 1);
        tbl[1]  = mk(1, 1, 0, 1, 2'd0, 12'h000, 0, 1);
        tbl[2]  = mk(1, 1, 0, 1, 2'd0, 12'h000, 0, 1);
        tbl[3]  = mk(0, 1, 0, 1, 2'd0, 12'h00F, 0, 0);
        tbl[4]  = mk(0, 0, 0, 1, 2'd0, 12'h00F, 0, 0);
        tbl[5]  = mk(0, 1, 0, 1, 2'd1, 12'h00F, 1, 1);
        tbl[6]  = mk(0, 1, 0, 1, 2'd1, 12'h5A3, 1, 0);
        tbl[7]  = mk(0, 0, 0, 1, 2'd1, 12'h5A3, 1, 0);
        tbl[8]  = mk(0, 1, 1, 1, 2'd2, 12'h5A3, 0, 0);
        tbl[9]  = mk(0, 0, 1, 1, 2'd2, 12'h5A3, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 2'd2, 12'h5A3, 0, 0);
        tbl[11] = mk(0, 0, 0, 1, 2'd2, 12'h5A3, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 2'd2, 12'h5A3, 0, 0);
        tbl[13] = mk(0, 0, 0, 1, 2'd2, 12'hF00, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 2'd2, 12'hF00, 0, 0);
        tbl[15] = mk(0, 0, 0, 1, 2'd2, 12'hF00, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 2'd3, 12'hF00, 0, 0);
        tbl[17] = mk(0, 0, 0, 1, 2'd3, 12'h000, 0, 0);

        reset_in     = 1'b1;
        vsync        = 1'b1;
        blank        = 1'b0;
        start_btn    = 1'b1;
        player_dead  = 1'b0;
        game_rgb     = 12'h5A3;
        gameover_rgb = 12'hFFF;

        for (int i = 0; i < 18; i++) begin
            reset_in    = tbl[i].rst;
            start_btn   = tbl[i].start;
            player_dead = tbl[i].dead;
            vsync       = tbl[i].vs;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].rgb, tbl[i].run, tbl[i].grst);
        end

        // Fade-in with one level per frame; a full-white image shows {lvl,lvl,lvl}
        for (int lvl = 1; lvl <= 15; lvl++) begin
            frame();
            chk($sformatf("fade%0d.rgb", lvl), rgb_out, {3{4'(lvl)}});
            chk($sformatf("fade%0d.state", lvl), 12'(state_out), 12'd3);
            if (lvl == 5) begin
                start_btn = 1'b1;
                step();
                chk("early_start.state", 12'(state_out), 12'd3);
                start_btn = 1'b0;
                step();
            end
            if (lvl == 7) begin
                gameover_rgb = 12'h8C4;
                step();
                chk("fade7_mixed.rgb", rgb_out, 12'h462);
                gameover_rgb = 12'hFFF;
                step();
            end
        end
        frame();
        chk("fade_sat.rgb", rgb_out, 12'hFFF);
        chk("fade_sat.state", 12'(state_out), 12'd3);

        start_btn = 1'b1;
        step();
        chk_all("replay", 2'd1, 12'hFFF, 1'b1, 1'b1);
        start_btn = 1'b0;
        step();
        chk_all("replay2", 2'd1, 12'h5A3, 1'b1, 1'b0);

        // Blank reaches the output three clocks after it rises
        blank = 1'b1;
        step();
        chk("blank1.rgb", rgb_out, 12'h5A3);
        step();
        chk("blank2.rgb", rgb_out, 12'h5A3);
        step();
        chk("blank3.rgb", rgb_out, 12'h000);
        blank = 1'b0;
        step();
        chk("unblank1.rgb", rgb_out, 12'h000);
        step();
        chk("unblank2.rgb", rgb_out, 12'h000);
        step();
        chk("unblank3.rgb", rgb_out, 12'h5A3);

        // Reset pulse while flashing in DYING
        player_dead = 1'b1;
        step();
        chk_all("die2", 2'd2, 12'h5A3, 1'b0, 1'b0);
        player_dead = 1'b0;
        frame();
        frame();
        chk("die2_flash.rgb", rgb_out, 12'hF00);
        reset_in = 1'b1;
        step();
        chk_all("midreset", 2'd0, 12'h000, 1'b0, 1'b1);
        reset_in = 1'b0;
        step();
        chk_all("midreset_rel", 2'd0, 12'h00F, 1'b0, 1'b0);
        start_btn = 1'b1;
        step();
        chk_all("restart", 2'd1, 12'h00F, 1'b1, 1'b1);
        player_dead = 1'b1;
        step();
        player_dead = 1'b0;
        step();
        chk("redie_noflash.rgb", rgb_out, 12'h5A3);
        chk("redie.state", 12'(state_out), 12'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
